// File: rtl/imem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_ctrl
// Brief    : Access controller sharing a single-ported, synchronous-read
//            instruction memory between the fetch stage (reads) and a
//            loader/debug port (writes). Aligns/range-checks addresses and
//            bounds loader priority so fetch cannot starve unless locked out.
// Revision : 1.0 - initial release
// ============================================================================
module imem_ctrl #(
    parameter int MEM_SIZE     = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    // fetch requester
    input  logic        FetchReq,
    input  logic [31:0] FetchAddr,
    output logic        FetchGnt,
    output logic        FetchValid,
    output logic [31:0] FetchData,
    output logic        FetchErr,
    // loader requester
    input  logic        LoadReq,
    input  logic [31:0] LoadAddr,
    input  logic [31:0] LoadData,
    input  logic        LoadLock,
    output logic        LoadGnt,
    output logic        LoadErr,
    // memory side
    output logic        MemEn,
    output logic        MemWe,
    output logic [29:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData
);

    // Counter must hold values 0..STARVE_LIMIT inclusive.
    localparam int              c_SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
    localparam logic [29:0]     c_MEM_WORDS  = 30'(MEM_SIZE);

    logic [c_SW-1:0] r_starve;
    logic            r_fetch_out;   // a fetch was granted last cycle
    logic            r_fetch_err;   // ...and its address was invalid
    logic            r_load_err;    // an invalid write was granted last cycle

    logic            w_fetch_gnt;
    logic            w_load_gnt;
    logic [c_SW-1:0] w_starve_nxt;
    logic            w_fetch_ok;
    logic            w_load_ok;
    logic            w_fetch_go;
    logic            w_load_go;

    // Address legality: word aligned and inside the memory.
    always_comb begin
        w_fetch_ok = (FetchAddr[1:0] == 2'b00) && (FetchAddr[31:2] < c_MEM_WORDS);
        w_load_ok  = (LoadAddr[1:0]  == 2'b00) && (LoadAddr[31:2]  < c_MEM_WORDS);
    end

    // Arbitration: lock > starvation-forced fetch > loader > fetch.
    // Grants are suppressed while reset is asserted so every output is 0.
    always_comb begin
        w_fetch_gnt  = 1'b0;
        w_load_gnt   = 1'b0;
        w_starve_nxt = r_starve;
        if (reset_n) begin
            if (LoadLock) begin
                // exclusive loader ownership; starvation count frozen
                w_load_gnt = LoadReq;
            end else if (FetchReq && LoadReq && (r_starve == c_STARVE_MAX)) begin
                w_fetch_gnt  = 1'b1;
                w_starve_nxt = '0;
            end else if (LoadReq) begin
                w_load_gnt = 1'b1;
                if (FetchReq) begin
                    w_starve_nxt = (r_starve == c_STARVE_MAX) ? r_starve
                                                              : r_starve + 1'b1;
                end else begin
                    w_starve_nxt = '0;
                end
            end else if (FetchReq) begin
                w_fetch_gnt  = 1'b1;
                w_starve_nxt = '0;
            end
        end
    end

    // Memory drive: only legal granted accesses reach the array.
    always_comb begin
        w_fetch_go = w_fetch_gnt & w_fetch_ok;
        w_load_go  = w_load_gnt  & w_load_ok;
        MemEn      = w_fetch_go | w_load_go;
        MemWe      = w_load_go;
        MemWData   = w_load_go ? LoadData : 32'h0;
        if (w_load_go) begin
            MemAddr = LoadAddr[31:2];
        end else if (w_fetch_go) begin
            MemAddr = FetchAddr[31:2];
        end else begin
            MemAddr = 30'h0;
        end
    end

    // Starvation counter and one-deep fetch/error pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve    <= '0;
            r_fetch_out <= 1'b0;
            r_fetch_err <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_starve    <= w_starve_nxt;
            r_fetch_out <= w_fetch_gnt;
            r_fetch_err <= w_fetch_gnt & ~w_fetch_ok;
            r_load_err  <= w_load_gnt & ~w_load_ok;
        end
    end

    // Response outputs; read data is forced to 0 unless a good read returns.
    always_comb begin
        FetchGnt   = w_fetch_gnt;
        LoadGnt    = w_load_gnt;
        FetchValid = r_fetch_out;
        FetchErr   = r_fetch_err;
        LoadErr    = r_load_err;
        FetchData  = (r_fetch_out && !r_fetch_err) ? MemRData : 32'h0;
    end

endmodule
`default_nettype wire
